// File: rtl/renode_irq_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : renode_irq_event_queue
// Description : Synchronises interrupt lines, detects changes per line using a
//               runtime mode (level / rising / falling / masked), coalesces
//               them into pending bits, arbitrates round-robin and buffers
//               {index, value} events in a first-word fall-through FIFO that
//               the Renode connection layer drains with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module renode_irq_event_queue #(
    parameter int InterruptsCount = 1,
    parameter int SyncStages      = 2,
    parameter int FifoDepth       = 4,
    localparam int IndexWidth     = $clog2((InterruptsCount > 1) ? InterruptsCount : 2),
    localparam int LevelWidth     = $clog2(FifoDepth + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [InterruptsCount-1:0]   interrupts,
    input  logic [2*InterruptsCount-1:0] mode,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [IndexWidth-1:0]        evt_index,
    output logic                         evt_value,
    output logic [InterruptsCount-1:0]   pending,
    output logic [LevelWidth-1:0]        fifo_level,
    output logic                         coalesced,
    input  logic                         coalesced_clear
);

    localparam int AddrWidth = $clog2(FifoDepth);
    localparam logic [LevelWidth-1:0] c_FULL_LEVEL = LevelWidth'(FifoDepth);

    // ------------------------------------------------------------------
    // Synchroniser chain; zero stages passes the raw lines straight through.
    // ------------------------------------------------------------------
    logic [InterruptsCount-1:0] sync_s;

    generate
        if (SyncStages == 0) begin : g_nosync
            assign sync_s = interrupts;
        end else begin : g_sync
            logic [InterruptsCount-1:0] stage_q [SyncStages];

            // Shift each line through SyncStages flops
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SyncStages; k++) stage_q[k] <= '0;
                end else begin
                    stage_q[0] <= interrupts;
                    for (int k = 1; k < SyncStages; k++) stage_q[k] <= stage_q[k-1];
                end
            end

            assign sync_s = stage_q[SyncStages-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [InterruptsCount-1:0] prev_q;
    logic [InterruptsCount-1:0] pending_q, pending_d;
    logic [InterruptsCount-1:0] val_q, val_d;
    logic [IndexWidth-1:0]      ptr_q, ptr_d;
    logic [AddrWidth-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LevelWidth-1:0]      count_q, count_d;
    logic                       coalesced_q, coalesced_d;
    logic [IndexWidth:0]        mem_q [FifoDepth];

    logic [InterruptsCount-1:0] event_w;
    logic                       grant_found;
    logic [IndexWidth-1:0]      grant_idx;
    logic                       grant;
    logic                       pop;
    logic                       coal_set;

    assign pop   = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign grant = grant_found & ((count_q != c_FULL_LEVEL) | pop);

    // Per-line change detection filtered by the line's current mode
    always_comb begin
        event_w = '0;
        for (int i = 0; i < InterruptsCount; i++) begin
            case (mode[2*i +: 2])
                2'b00:   event_w[i] = sync_s[i] ^ prev_q[i];
                2'b01:   event_w[i] = (sync_s[i] ^ prev_q[i]) & sync_s[i];
                2'b10:   event_w[i] = (sync_s[i] ^ prev_q[i]) & ~sync_s[i];
                default: event_w[i] = 1'b0;
            endcase
        end
    end

    // Round-robin search for the first pending line at or after ptr
    always_comb begin : arb
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < InterruptsCount; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= InterruptsCount) idx = idx - InterruptsCount;
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IndexWidth'(idx);
            end
        end
    end

    // Pending/value update; a new event on the granted line re-arms it
    always_comb begin
        pending_d = pending_q;
        val_d     = val_q;
        coal_set  = 1'b0;
        for (int i = 0; i < InterruptsCount; i++) begin
            if (grant && (grant_idx == IndexWidth'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (event_w[i]) begin
                if (pending_q[i] && !(grant && (grant_idx == IndexWidth'(i)))) begin
                    coal_set = 1'b1;
                end
                pending_d[i] = 1'b1;
                val_d[i]     = sync_s[i];
            end
        end
    end

    // Pointer, occupancy and sticky coalesced flag next-state
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            if (int'(grant_idx) == InterruptsCount - 1) ptr_d = '0;
            else                                        ptr_d = grant_idx + 1'b1;
        end
        count_d = count_q;
        if (grant && !pop)      count_d = count_q + 1'b1;
        else if (!grant && pop) count_d = count_q - 1'b1;
        coalesced_d = coalesced_q;
        if (coalesced_clear) coalesced_d = 1'b0;
        if (coal_set)        coalesced_d = 1'b1;
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            pending_q   <= '0;
            val_q       <= '0;
            ptr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            coalesced_q <= 1'b0;
        end else begin
            prev_q      <= sync_s;
            pending_q   <= pending_d;
            val_q       <= val_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            coalesced_q <= coalesced_d;
            if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are only observable while occupied
    always_ff @(posedge clk) begin
        if (grant) mem_q[wr_ptr_q] <= {grant_idx, val_q[grant_idx]};
    end

    assign evt_valid  = (count_q != '0);
    assign evt_index  = evt_valid ? mem_q[rd_ptr_q][IndexWidth:1] : '0;
    assign evt_value  = evt_valid ? mem_q[rd_ptr_q][0] : 1'b0;
    assign pending    = pending_q;
    assign fifo_level = count_q;
    assign coalesced  = coalesced_q;

endmodule
`default_nettype wire

// File: doc/renode_irq_event_queue.md
# renode_irq_event_queue

Parametrised successor to the single-channel interrupt forwarding in the co-simulation top. It synchronises up to 256 interrupt lines and applies a per-line runtime detection mode. Detected changes are coalesced into per-line pending bits, arbitrated round-robin, and buffered in a FIFO of {index, value} events. The Renode connection layer drains the FIFO through a valid/ready handshake. It sits between the DUT interrupt outputs and the message sender that emits interrupt-change messages.

## Interface
- InterruptsCount, 1: number of interrupt lines, 1..256.
- SyncStages, 2: synchroniser flops per line, 0..4. 0 means the input is used directly.
- FifoDepth, 4: event FIFO entries. Power of two, at least 2.
- IndexWidth, derived: $clog2(max(InterruptsCount,2)).
- clk  in  1  sole clock.
- rst  in  1  asynchronous reset, active-high.
- interrupts  in  InterruptsCount  raw interrupt lines from the DUT.
- mode  in  2*InterruptsCount  per-line mode, bits [2i+1:2i]:
  - 00: level, report every change.
  - 01: report rising edges only.
  - 10: report falling edges only.
  - 11: masked.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head.
- evt_index  out  IndexWidth  line number of the head event.
- evt_value  out  1  synchronised line value at detection (latest value if coalesced).
- pending  out  InterruptsCount  per-line detected-but-not-enqueued bits.
- fifo_level  out  $clog2(FifoDepth+1)  occupied entries.
- coalesced  out  1  sticky: an event hit a line whose pending bit was already set.
- coalesced_clear  in  1  synchronous clear of coalesced.

## Operation
- Synchroniser: s[i] is interrupts[i] delayed by SyncStages flops. prev[i] <= s[i] every cycle, regardless of mode.
- Detect:
  - change[i] = s[i] ^ prev[i].
  - event[i] = change[i] & (mode==00 | (mode==01 & s[i]) | (mode==10 & !s[i])).
  - Mode 11 yields no event.
- Pending: on event[i], pending[i] <= 1 and val[i] <= s[i].
  - If pending[i] was already 1 and is not granted this cycle, coalesced <= 1. Only one entry is later emitted, carrying the newest value.
- Arbiter: round-robin over pending, starting at ptr.
  - Grants one line per cycle when the FIFO can accept: not full, or a pop in the same cycle.
  - On grant g: {g, val[g]} is pushed, pending[g] cleared, ptr <= g+1 (wraps to 0 after InterruptsCount-1).
  - If event[g] fires in the grant cycle, pending[g] stays 1 with the new value. This is not a coalescing event.
- FIFO:
  - First-word fall-through: evt_index/evt_value present the head while evt_valid=1.
  - Pop on evt_valid & evt_ready.
  - Simultaneous push and pop when full is allowed; level unchanged.
  - Pointers wrap modulo FifoDepth.
- Backpressure: a full FIFO with no pop blocks grants. Events keep accumulating in pending and are never dropped.
- Mode change: takes effect in the cycle it is applied. Masking a line does not clear its pending bit; the queued event is still delivered.
- coalesced_clear:
  - Clears coalesced next edge.
  - If a coalescing event occurs in the same cycle, set wins.

## Timing
- Reset values:
  - All synchroniser flops, prev, pending, val, ptr, FIFO pointers: 0.
  - evt_valid=0, fifo_level=0, coalesced=0, evt_index=0, evt_value=0.
- After reset release, a line held high produces a 0->1 change. This reports the initial state to Renode in modes 00 and 01.
- Latency from the first sampling edge E of a stable input change, with the FIFO empty and no contention:
  - pending set at edge E+SyncStages.
  - FIFO push at E+SyncStages+1.
  - evt_valid high after that edge.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation clears everything asynchronously. Queued and pending events are lost by design; the reconnect logic resends state.
- evt_index/evt_value hold stable while evt_valid=1 and evt_ready=0.

## Test plan
- Reset, then single line:
  - Setup: InterruptsCount=4, SyncStages=2, all modes 00, evt_ready=1.
  - Stimulus: raise interrupts[2] before edge 10.
  - Required: pending[2] at edge 12; evt_valid high after edge 13 with index 2, value 1; one beat only.
- Edge modes:
  - Setup: line0 mode 01, line1 mode 10, line2 mode 11.
  - Stimulus: pulse all three high for 5 cycles.
  - Required: exactly two events, {0,1} then {1,0}; pending[2] never set.
- Round-robin under backpressure:
  - Setup: FifoDepth=4, evt_ready=0.
  - Stimulus: raise lines 0-3 together; then set evt_ready=1 and hold.
  - Required: fifo_level reaches 4 in order 0,1,2,3. Then toggle line 0 twice, then line 3 once: line 3 granted before line 0 when ptr=3.
- Coalescing:
  - Setup: FIFO full, evt_ready=0.
  - Stimulus: toggle line 1 0->1->0.
  - Required: coalesced=1; after draining, exactly one {1,0} entry. coalesced_clear returns it to 0.
- Full with simultaneous push/pop:
  - Setup: FIFO full, one pending line.
  - Stimulus: evt_ready=1 for one cycle.
  - Required: level stays 4; head advances; new entry at tail.
- Reset mid-burst:
  - Stimulus: assert rst with 3 queued and 2 pending.
  - Required: immediately evt_valid=0, fifo_level=0, pending=0. After release, lines still high re-report as value 1.
